// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
//   ADDR_W / DATA_W / BE_W : Avalon-MM command field widths (word address,
//                            16-bit data, 2 byte lanes).
//   arb_state_e            : arbiter FSM state encoding.
//   port_id_t              : identifies the issuing master (0 = CPU, 1 = DMA).
package sdram_arb_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order tag FIFO recording which master issued each outstanding read.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i  : write a tag (ignored while full, even if popping)
//   pop_i          : drop the head tag (ignored while empty)
//   head_o         : tag at the head of the FIFO
//   full_o/empty_o : occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  port_id_t din_i,
    input  logic     pop_i,
    output port_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    port_id_t    mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {PW{1'b0}}};
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single SDRAM controller slave.
// Port 0 is the CPU data master, port 1 the streaming/DMA master.
// Ports:
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   mN_address/read/write/
//   writedata/byteenable        : master N command inputs
//   mN_waitrequest              : master N stall
//   mN_readdata/readdatavalid   : master N read return (data shared, strobe routed)
//   s_*                         : SDRAM controller slave command/response
//   err_underflow               : sticky, read data returned with no read outstanding
// Parameters: MAX_HOLD (transfers per grant while the other port waits),
//             TAG_DEPTH (outstanding reads, power of 2).
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed priority with port 0 preferred.
//
// state  | meaning
// IDLE   | no grant; slave strobes low; both masters stalled
// GRANT0 | port 0 drives the slave command
// GRANT1 | port 1 drives the slave command
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int MAX_HOLD  = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              err_underflow
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] GRANT0 = ST_GRANT0;
    localparam logic [1:0] GRANT1 = ST_GRANT1;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [1:0] state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] hold_cnt_inc;
    logic       err_q, err_d;
    logic       pick1;

`ifdef SDRAM_ARB_RR_EN
    logic       last_q, last_d;
`else
    logic       pref1_q, pref1_d;
`endif

    logic       req0, req1;
    logic       grant0, grant1;
    logic       sel_read, sel_write;
    logic       blk;
    logic       accept;
    logic       tag_push, tag_pop;
    logic       tag_full, tag_empty;
    port_id_t   tag_head;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign grant0 = (state_q == GRANT0);
    assign grant1 = (state_q == GRANT1);

    // Command mux: the granted port drives the slave directly.
    always_comb begin
        sel_read     = 1'b0;
        sel_write    = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (grant0) begin
            sel_read     = m0_read;
            sel_write    = m0_write;
            s_address    = m0_address;
            s_writedata  = m0_writedata;
            s_byteenable = m0_byteenable;
        end else if (grant1) begin
            sel_read     = m1_read;
            sel_write    = m1_write;
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end
    end

    // A read cannot issue without a free tag slot; writes are never blocked.
    assign blk     = sel_read & tag_full;
    assign s_read  = sel_read & ~blk;
    assign s_write = sel_write;

    assign m0_waitrequest = grant0 ? (s_waitrequest | blk) : 1'b1;
    assign m1_waitrequest = grant1 ? (s_waitrequest | blk) : 1'b1;

    assign accept   = (s_read | s_write) & ~s_waitrequest;
    assign tag_push = s_read & ~s_waitrequest;
    assign tag_pop  = s_readdatavalid & ~tag_empty;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = tag_pop & (tag_head == 1'b0);
    assign m1_readdatavalid = tag_pop & (tag_head == 1'b1);

    assign err_d         = err_q | (s_readdatavalid & tag_empty);
    assign err_underflow = err_q;

    assign hold_cnt_inc = (accept && hold_cnt_q != HOLD_MAX) ? hold_cnt_q + 4'd1
                                                             : hold_cnt_q;

    // The hold limit is tested on the count including this cycle's transfer,
    // so the release happens in the same cycle the limit-th transfer is
    // accepted and no extra transfer slips through while leaving.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pick1      = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        last_d     = last_q;
`else
        pref1_d    = pref1_q;
`endif
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
`ifdef SDRAM_ARB_RR_EN
                pick1 = req1 & (~req0 | ~last_q);
                if (pick1) begin
                    last_d = 1'b1;
                end else if (req0) begin
                    last_d = 1'b0;
                end
`else
                // After port 0 was cut off by the hold limit, port 1 gets
                // this one IDLE cycle's decision.
                pick1   = req1 & (~req0 | pref1_q);
                pref1_d = 1'b0;
`endif
                if (pick1) begin
                    state_d = GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end
            end
            GRANT0: begin
                hold_cnt_d = hold_cnt_inc;
                if (!req0 || (hold_cnt_inc == HOLD_MAX && req1)) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
`ifndef SDRAM_ARB_RR_EN
                    pref1_d    = req0;
`endif
                end
            end
            GRANT1: begin
                hold_cnt_d = hold_cnt_inc;
                if (!req1 || (hold_cnt_inc == HOLD_MAX && req0)) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pref1_q <= 1'b0;
        end else begin
            pref1_q <= pref1_d;
        end
    end
`endif

    sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (tag_push),
        .din_i   (grant1),
        .pop_i   (tag_pop),
        .head_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations plus a
// queue-based transaction model compared on every cycle.
module tb_sdram_arbiter;

    localparam int MAX_HOLD  = 8;
    localparam int TAG_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [23:0] s_address;
    logic        s_read, s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.MAX_HOLD(MAX_HOLD), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .err_underflow(err_underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // owner: -1 no grant, else granted port; tags: issuing port per outstanding read.
    int  m_owner;
    int  m_cnt;
    bit  m_tags[$];
    bit  m_err;
    bit  m_pref1;
    bit  m_last;
    bit  m_valid = 1'b0;

    logic e_rd, e_wr, e_blk, e_sr, e_sw, e_w0, e_w1, e_v0, e_v1, r0, r1, rk, ro;

    always @(negedge clk) begin
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        e_sr = 0; e_sw = 0; e_w0 = 1; e_w1 = 1; e_v0 = 0; e_v1 = 0; e_blk = 0;
        if (m_owner >= 0) begin
            e_rd  = (m_owner == 1) ? m1_read : m0_read;
            e_wr  = (m_owner == 1) ? m1_write : m0_write;
            e_blk = e_rd && (m_tags.size() == TAG_DEPTH);
            e_sr  = e_rd && !e_blk;
            e_sw  = e_wr;
            if (m_owner == 1) e_w1 = s_waitrequest | e_blk;
            else              e_w0 = s_waitrequest | e_blk;
        end
        if (s_readdatavalid && m_tags.size() > 0) begin
            if (m_tags[0]) e_v1 = 1; else e_v0 = 1;
        end

        if (m_valid) begin
            chk("model_strobes", {26'd0, s_read, s_write, m0_waitrequest, m1_waitrequest,
                                  m0_readdatavalid, m1_readdatavalid},
                                 {26'd0, e_sr, e_sw, e_w0, e_w1, e_v0, e_v1});
            chk("model_err", {31'd0, err_underflow}, {31'd0, m_err});
            chk("model_rdata", {m0_readdata, m1_readdata}, {s_readdata, s_readdata});
            if (m_owner == 0)
                chk("model_cmd0", {s_address, 6'd0, s_byteenable}, {m0_address, 6'd0, m0_byteenable});
            if (m_owner == 1)
                chk("model_cmd1", {s_address, 6'd0, s_byteenable}, {m1_address, 6'd0, m1_byteenable});
            if (m_owner >= 0 && e_sw)
                chk("model_wdata", {16'd0, s_writedata},
                    {16'd0, (m_owner == 1) ? m1_writedata : m0_writedata});
        end

        // advance to the state after the coming rising edge
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_tags.delete(); m_err = 0;
            m_pref1 = 0; m_last = 1; m_valid = 1;
        end else if (m_valid) begin
            if (s_readdatavalid) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_err = 1;
            end
            if (e_sr && !s_waitrequest) m_tags.push_back(m_owner == 1);
            if (m_owner < 0) begin
                m_cnt = 0;
`ifdef SDRAM_ARB_RR_EN
                if (r0 && r1) m_owner = m_last ? 0 : 1;
                else if (r0)  m_owner = 0;
                else if (r1)  m_owner = 1;
                if (m_owner >= 0) m_last = (m_owner == 1);
`else
                if (r1 && (!r0 || m_pref1)) m_owner = 1;
                else if (r0)                m_owner = 0;
                m_pref1 = 0;
`endif
            end else begin
                if ((e_sr || e_sw) && !s_waitrequest && m_cnt < MAX_HOLD) m_cnt++;
                rk = (m_owner == 1) ? r1 : r0;
                ro = (m_owner == 1) ? r0 : r1;
                if (!rk || (m_cnt == MAX_HOLD && ro)) begin
                    m_pref1 = (m_owner == 0) && rk;
                    m_owner = -1;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 2'b11;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 2'b11;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    int n0, n1, idle_k, first1;
    bit acc;

    initial begin
        clear_inputs();
        rst = 1;
        cyc();
        #2;
        chk("rst_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
        chk("rst_strobes", {28'd0, s_read, s_write, m0_readdatavalid, m1_readdatavalid}, 32'd0);
        chk("rst_err", {31'd0, err_underflow}, 32'd0);
        cyc();
        rst = 0;

        // single m0 read, return three cycles after issue
        m0_read = 1; m0_address = 24'h000010;
        #2;
        chk("t1_c0_sread", {31'd0, s_read}, 32'd0);
        chk("t1_c0_wait0", {31'd0, m0_waitrequest}, 32'd1);
        cyc();
        #2;
        chk("t1_c1_sread", {31'd0, s_read}, 32'd1);
        chk("t1_c1_addr", {8'd0, s_address}, 32'h10);
        chk("t1_c1_wait0", {31'd0, m0_waitrequest}, 32'd0);
        cyc();
        m0_read = 0;
        cyc();
        cyc();
        s_readdatavalid = 1; s_readdata = 16'hBEEF;
        #2;
        chk("t1_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd2);
        chk("t1_rdata", {16'd0, m0_readdata}, 32'hBEEF);
        cyc();
        s_readdatavalid = 0;
        cyc();

        // simultaneous requests from reset, m0 held to MAX_HOLD writes
        do_reset();
        m0_write = 1; m0_address = 24'h000100;
        m1_write = 1; m1_address = 24'h000200; m1_writedata = 16'h5A5A;
        n0 = 0; idle_k = -1; first1 = -1;
        for (int k = 0; k < 14; k++) begin
            s_waitrequest = (k == 3);
            m0_writedata = 16'h1000 + 16'(k);
            #2;
            if (k == 1) begin
                chk("t2_grant0_addr", {8'd0, s_address}, 32'h100);
                chk("t2_grant0_wait1", {31'd0, m1_waitrequest}, 32'd1);
            end
            if (!m0_waitrequest) n0++;
            if (!m1_waitrequest && first1 < 0) first1 = k;
            if (k > 0 && !s_write && idle_k < 0) idle_k = k;
            cyc();
        end
        chk("t3_m0_accepts", n0, 32'd8);
        chk("t3_idle_cycle", idle_k, 32'd10);
        chk("t3_grant1_cycle", first1, 32'd11);
        m0_write = 0; m1_write = 0; s_waitrequest = 0;
        cyc();
        cyc();

        // m1 fills the tag FIFO, stalls, resumes after one return
        do_reset();
        m1_read = 1; m1_address = 24'h000300;
        n1 = 0;
        for (int k = 0; k < 13; k++) begin
            s_readdatavalid = (k == 11);
            s_readdata = 16'h7000;
            #2;
            acc = !m1_waitrequest;
            if (acc) n1++;
            if (k == 9) begin
                chk("t4_full_sread", {31'd0, s_read}, 32'd0);
                chk("t4_full_wait1", {31'd0, m1_waitrequest}, 32'd1);
            end
            if (k == 11) begin
                chk("t4_pop_sread", {31'd0, s_read}, 32'd0);
                chk("t4_pop_rdv1", {31'd0, m1_readdatavalid}, 32'd1);
            end
            if (k == 12) chk("t4_resume_sread", {31'd0, s_read}, 32'd1);
            cyc();
            if (acc) m1_address = m1_address + 24'd1;
        end
        chk("t4_m1_accepts", n1, 32'd9);
        m1_read = 0;
        for (int i = 0; i < 8; i++) begin
            s_readdatavalid = 1; s_readdata = 16'hA000 + 16'(i);
            #2;
            chk("t4_ret_route", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd1);
            cyc();
        end
        s_readdatavalid = 0;
        cyc();

        // stray return: no routing, sticky error
        s_readdatavalid = 1; s_readdata = 16'hDEAD;
        #2;
        chk("t5_err_before", {31'd0, err_underflow}, 32'd0);
        chk("t5_no_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
        cyc();
        s_readdatavalid = 0;
        #2;
        chk("t5_err_set", {31'd0, err_underflow}, 32'd1);
        cyc(); cyc(); cyc();
        chk("t5_err_sticky", {31'd0, err_underflow}, 32'd1);

        // reset during a GRANT1 burst with three reads outstanding
        m1_read = 1; m1_address = 24'h000400;
        cyc(); cyc(); cyc(); cyc();
        m1_read = 0;
        rst = 1;
        cyc();
        rst = 0;
        s_readdatavalid = 1; s_readdata = 16'h1234;
        #2;
        chk("t6_rst_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
        chk("t6_rst_sread", {31'd0, s_read}, 32'd0);
        chk("t6_rst_err", {31'd0, err_underflow}, 32'd0);
        chk("t6_stray_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
        cyc();
        s_readdatavalid = 0;
        #2;
        chk("t6_err_set", {31'd0, err_underflow}, 32'd1);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
